// File: rtl/multi_comb_filter.sv
// Multi-channel feedback comb filter, time-multiplexed over CHANNELS.
// Each channel owns a circular history of MAX_DEPTH samples; the output is
// the sample from D accepted samples ago, and the stored value is
// sat(in>>>IN_SHIFT + (delayed*gain)>>>GAIN_W). Two-cycle latency:
// cycle 0 accepts the sample and reads history, cycle 1 computes, writes and
// registers the result.
module multi_comb_filter #(
    parameter int WIDTH     = 32,
    parameter int MAX_DEPTH = 2048,
    parameter int CHANNELS  = 2,
    parameter int GAIN_W    = 16,
    parameter int IN_SHIFT  = 1,
    localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW  = $clog2(MAX_DEPTH),
    localparam int DLW = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [CW-1:0]     in_ch,
    input  logic [WIDTH-1:0]  in,
    input  logic [DLW-1:0]    delay_len,
    input  logic [GAIN_W-1:0] gain,
    output logic              out_valid,
    output logic [CW-1:0]     out_ch,
    output logic [WIDTH-1:0]  out
);

    localparam int PW = WIDTH + GAIN_W + 1;
    localparam logic [CW-1:0] CH_MASK = CW'(CHANNELS - 1);
    localparam logic signed [PW-1:0] SAT_MAX = {{(GAIN_W + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(GAIN_W + 2){1'b1}}, {(WIDTH - 1){1'b0}}};

    // Per-channel history, write pointer and "history is full" flag
    logic [WIDTH-1:0]    r_mem [CHANNELS][MAX_DEPTH];
    logic [AW-1:0]       r_ptr [CHANNELS];
    logic [CHANNELS-1:0] r_primed;

    // Accept-stage signals
    logic [CW-1:0]  w_ch;
    logic [DLW-1:0] w_d;
    logic [AW-1:0]  w_ptr_cur;
    logic [AW-1:0]  w_ptr_eff;
    logic [AW-1:0]  w_ptr_next;
    logic           w_primed_cur;
    logic           w_wrap;

    // Compute-stage registers
    logic              r_s1_valid;
    logic              r_s1_en;
    logic [CW-1:0]     r_s1_ch;
    logic [AW-1:0]     r_s1_ptr;
    logic              r_s1_primed;
    logic [WIDTH-1:0]  r_s1_in;
    logic [GAIN_W-1:0] r_s1_gain;
    logic [WIDTH-1:0]  r_rd_data;
    logic              r_fwd_hit;
    logic [WIDTH-1:0]  r_fwd_data;

    // Compute-stage signals
    logic                    w_wr_en;
    logic [WIDTH-1:0]        w_delayed;
    logic signed [WIDTH-1:0] w_in_sh;
    logic signed [PW-1:0]    w_prod;
    logic signed [PW-1:0]    w_sum;
    logic [WIDTH-1:0]        w_wr_data;

    // Output registers
    logic             r_out_valid;
    logic [CW-1:0]    r_out_ch;
    logic [WIDTH-1:0] r_out;

    // Clamp the delay, pick the read slot (flush acts as if already cleared) and the next pointer
    always_comb begin
        w_ch = in_ch & CH_MASK;
        if (delay_len == '0) begin
            w_d = DLW'(1);
        end else if (delay_len > DLW'(MAX_DEPTH)) begin
            w_d = DLW'(MAX_DEPTH);
        end else begin
            w_d = delay_len;
        end
        w_ptr_cur    = flush ? '0 : r_ptr[w_ch];
        w_primed_cur = flush ? 1'b0 : r_primed[w_ch];
        // A pointer left beyond a shortened delay restarts at slot 0
        w_ptr_eff    = ({1'b0, w_ptr_cur} >= w_d) ? '0 : w_ptr_cur;
        w_wrap       = ({1'b0, w_ptr_eff} >= (w_d - DLW'(1)));
        w_ptr_next   = w_wrap ? '0 : (w_ptr_eff + AW'(1));
    end

    // Pointer / primed state: cleared by reset, bypass or flush; only the addressed channel advances
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            for (int c = 0; c < CHANNELS; c++) r_ptr[c] <= '0;
            r_primed <= '0;
        end else begin
            if (flush) begin
                for (int c = 0; c < CHANNELS; c++) r_ptr[c] <= '0;
                r_primed <= '0;
            end
            if (in_valid) begin
                r_ptr[w_ch]    <= w_ptr_next;
                r_primed[w_ch] <= w_primed_cur | w_wrap;
            end
        end
    end

    // Capture the accepted sample; note when the read slot is written on this same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_en     <= 1'b0;
            r_s1_ch     <= '0;
            r_s1_ptr    <= '0;
            r_s1_primed <= 1'b0;
            r_s1_in     <= '0;
            r_s1_gain   <= '0;
            r_fwd_hit   <= 1'b0;
            r_fwd_data  <= '0;
        end else begin
            r_s1_valid  <= in_valid;
            r_s1_en     <= enable;
            r_s1_ch     <= w_ch;
            r_s1_ptr    <= w_ptr_eff;
            r_s1_primed <= enable & w_primed_cur;
            r_s1_in     <= in;
            r_s1_gain   <= gain;
            r_fwd_hit   <= w_wr_en && (r_s1_ch == w_ch) && (r_s1_ptr == w_ptr_eff);
            r_fwd_data  <= w_wr_data;
        end
    end

    // History memory: synchronous read for the new sample, write of the computed value
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_s1_ch][r_s1_ptr] <= w_wr_data;
        end
        r_rd_data <= r_mem[w_ch][w_ptr_eff];
    end

    // Delayed value (zero until primed, forwarded on a same-edge write) and saturated feedback sum
    always_comb begin
        w_wr_en = rst_n && r_s1_valid && r_s1_en;
        if (!r_s1_primed) begin
            w_delayed = '0;
        end else if (r_fwd_hit) begin
            w_delayed = r_fwd_data;
        end else begin
            w_delayed = r_rd_data;
        end
        w_in_sh = $signed(r_s1_in) >>> IN_SHIFT;
        w_prod  = $signed({{(GAIN_W + 1){w_delayed[WIDTH-1]}}, w_delayed})
                * $signed({{(WIDTH + 1){1'b0}}, r_s1_gain});
        w_sum   = (w_prod >>> GAIN_W) + $signed({{(GAIN_W + 1){w_in_sh[WIDTH-1]}}, w_in_sh});
        if (w_sum > SAT_MAX) begin
            w_wr_data = SAT_MAX[WIDTH-1:0];
        end else if (w_sum < SAT_MIN) begin
            w_wr_data = SAT_MIN[WIDTH-1:0];
        end else begin
            w_wr_data = w_sum[WIDTH-1:0];
        end
    end

    // Result register: delayed value when active, raw input in bypass; holds between results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out       <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_ch <= r_s1_ch;
                r_out    <= r_s1_en ? w_delayed : r_s1_in;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out       = r_out;

endmodule

// File: doc/multi_comb_filter.md
MULTI_COMB_FILTER -- requirements
Module: multi_comb_filter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, sample width in bits (signed two's complement).
REQ-002 SHALL have parameter MAX_DEPTH, default 2048, maximum delay per channel in samples (power of two).
REQ-003 SHALL have parameter CHANNELS, default 2, number of independent time-multiplexed channels (power of two, at least 1).
REQ-004 SHALL have parameter GAIN_W, default 16, feedback gain width; gain is unsigned Q0.GAIN_W.
REQ-005 SHALL have parameter IN_SHIFT, default 1, arithmetic right shift applied to input before summing.
REQ-006 SHALL have port clk, input, 1 bit, single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, reset, synchronous and active-low.
REQ-008 SHALL have port enable, input, 1 bit; 1 = filter active, 0 = bypass.
REQ-009 SHALL have port flush, input, 1 bit, single-cycle clear of all channel history.
REQ-010 SHALL have port in_valid, input, 1 bit, sample strobe; may be high every cycle.
REQ-011 SHALL have port in_ch, input, clog2(CHANNELS) bits, channel of the current sample (1 bit when CHANNELS is 1).
REQ-012 SHALL have port in, input, WIDTH bits, signed input sample.
REQ-013 SHALL have port delay_len, input, clog2(MAX_DEPTH)+1 bits, delay in samples.
REQ-014 SHALL have port gain, input, GAIN_W bits, feedback coefficient.
REQ-015 SHALL have port out_valid, output, 1 bit, result strobe.
REQ-016 SHALL have port out_ch, output, clog2(CHANNELS) bits, channel of the result.
REQ-017 SHALL have port out, output, WIDTH bits, signed result.

Function
REQ-018 SHALL keep, per channel, a circular buffer of MAX_DEPTH words, a pointer ptr[ch] and a primed[ch] flag.
REQ-019 SHALL sample delay_len and gain on every accepted sample; delay_len of 0 SHALL be treated as 1, and values above MAX_DEPTH SHALL be treated as MAX_DEPTH (effective length D).
REQ-020 SHALL, on an accepted sample in the active state, produce delayed = buf[ch][ptr[ch]] when primed[ch]=1, and delayed = 0 otherwise (never X).
REQ-021 SHALL write buf[ch][ptr[ch]] = sat(in>>>IN_SHIFT + (delayed*gain)>>>GAIN_W), where the sum is computed at full precision and saturated to the WIDTH signed range.
REQ-022 SHALL advance ptr[ch] to ptr[ch]+1, or to 0 when ptr[ch] >= D-1; when wrapping, it SHALL set primed[ch]=1.
REQ-023 SHALL force ptr[ch] to 0 when D shrinks below ptr[ch]+1, with no X and no out-of-range access.
REQ-024 SHALL drive out = delayed, with out_valid high exactly 2 cycles after the accepted in_valid and out_ch equal to the in_ch of that sample.
REQ-025 SHALL deliver correct results for back-to-back samples on the same channel, including D=1 at one sample per cycle, by forwarding pending writes to reads.
REQ-026 SHALL update only the addressed channel's state, so channels never interact.
REQ-027 SHALL, while enable=0, drive out = in and out_ch = in_ch with the same 2-cycle latency, write no memory, and hold all ptr at 0 and all primed at 0.
REQ-028 SHALL, on flush=1, set all ptr to 0 and all primed to 0 on that edge; a sample with in_valid and flush in the same cycle SHALL be processed as the first post-flush sample (delayed = 0).
REQ-029 SHALL hold out_valid low in every cycle that is not a result cycle, and SHALL hold out at its last value.

Reset
REQ-030 SHALL, on rst_n=0 at a clock edge, set out=0, out_valid=0, out_ch=0, all ptr=0, all primed=0, and clear the pipeline; memory contents need not be cleared.
REQ-031 SHALL ignore in_valid during reset, and SHALL accept the first sample on the first edge with rst_n=1.

Verification (WIDTH=32, MAX_DEPTH=16, CHANNELS=2, GAIN_W=16, IN_SHIFT=1)
REQ-032 SHALL verify the impulse case: ch0, D=4, gain=0x8000, in=1000 then 0 each cycle -> out 0 for samples 0-3, 500 at sample 4, 250 at 8, 125 at 12.
REQ-033 SHALL verify saturation: ch0, D=2, gain=0xFFFF, in=0x7FFFFFFF constant -> stored and output values rise, then pin at 0x7FFFFFFF with no wrap to negative.
REQ-034 SHALL verify channel isolation: interleaved ch0 impulse 1000 and ch1 all zeros, D=4 -> ch1 out always 0, and ch0 matches REQ-032.
REQ-035 SHALL verify forwarding: ch0, D=1, gain=0x8000, in_valid every cycle, in=1000 then 0 -> out 0, 500, 250, 125 on consecutive valid cycles.
REQ-036 SHALL verify bypass: enable=0, in=-7 -> out=-7, out_valid high 2 cycles later, out_ch matching; after re-enable, the first D outputs are 0.
REQ-037 SHALL verify reset mid-operation: rst_n=0 for 1 cycle during REQ-032 -> out=0 and out_valid=0 the next cycle, and the following impulse test reproduces REQ-032 exactly.
